// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: store write buffer + single-port word array + load port  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WB_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_en_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic        st_ready_o,
  input  logic        ld_en_i,
  input  logic [1:0]  ld_size_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_ready_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] r_wb_idx  [WB_DEPTH];
  logic [3:0]       r_wb_strb [WB_DEPTH];
  logic [31:0]      r_wb_data [WB_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_ld_valid;
  logic [31:0]      r_ld_data;
  logic             r_misalign;

  logic [IDX_W-1:0]    w_st_idx;
  logic [IDX_W-1:0]    w_ld_idx;
  logic                w_st_ready;
  logic                w_ld_ready;
  logic [WB_DEPTH-1:0] w_hit;
  logic                w_st_acc;
  logic                w_st_mis;
  logic                w_enq;
  logic                w_ld_acc;
  logic                w_ld_mis;
  logic                w_drain;
  logic [3:0]          w_st_strb;
  logic [31:0]         w_st_data;
  logic [31:0]         w_rd_shift;
  logic [31:0]         w_ld_result;
  logic                w_unused_addr_bits;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  assign w_st_idx           = st_addr_i[IDX_W+1:2];
  assign w_ld_idx           = ld_addr_i[IDX_W+1:2];
  assign w_unused_addr_bits = ^{st_addr_i[31:IDX_W+2], ld_addr_i[31:IDX_W+2]};

  // Slots freed by a drain only become visible on the following cycle.
  assign w_st_ready = (r_count < CNT_W'(WB_DEPTH));

  generate
    for (genvar i = 0; i < WB_DEPTH; i++) begin : g_hit
      logic [PTR_W-1:0] w_offset;
      assign w_offset = PTR_W'(i) - r_head;
      assign w_hit[i] = ({1'b0, w_offset} < r_count) && (r_wb_idx[i] == w_ld_idx);
    end
  endgenerate

  assign w_ld_ready = ~|w_hit;
  assign w_st_acc   = st_en_i & w_st_ready;
  assign w_st_mis   = is_misaligned(st_size_i, st_addr_i[1:0]);
  assign w_enq      = w_st_acc & ~w_st_mis;
  assign w_ld_acc   = ld_en_i & w_ld_ready;
  assign w_ld_mis   = is_misaligned(ld_size_i, ld_addr_i[1:0]);
  assign w_drain    = ~w_ld_acc & (r_count != '0);

  always_comb begin
    w_st_data = st_data_i << {st_addr_i[1:0], 3'b000};
    case (st_size_i)
      2'b00:   w_st_strb = 4'b0001 << st_addr_i[1:0];
      2'b01:   w_st_strb = 4'b0011 << st_addr_i[1:0];
      default: w_st_strb = 4'hF;
    endcase
  end

  always_comb begin
    w_rd_shift = r_mem[w_ld_idx] >> {ld_addr_i[1:0], 3'b000};
    case (ld_size_i)
      2'b00:   w_ld_result = {24'h0, w_rd_shift[7:0]};
      2'b01:   w_ld_result = {16'h0, w_rd_shift[15:0]};
      default: w_ld_result = w_rd_shift;
    endcase
    if (w_ld_mis) w_ld_result = 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ld_valid <= 1'b0;
      r_ld_data  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_enq)   r_tail <= r_tail + PTR_W'(1);
      if (w_drain) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_ld_valid <= w_ld_acc;
      if (w_ld_acc) r_ld_data <= w_ld_result;
      r_misalign <= (w_ld_acc & w_ld_mis) | (w_st_acc & w_st_mis);
    end
  end

  // Buffer payload and array contents carry no reset; validity comes from count.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_wb_idx[r_tail]  <= w_st_idx;
      r_wb_strb[r_tail] <= w_st_strb;
      r_wb_data[r_tail] <= w_st_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_drain) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wb_strb[r_head][b]) r_mem[r_wb_idx[r_head]][8*b +: 8] <= r_wb_data[r_head][8*b +: 8];
      end
    end
  end

  assign st_ready_o = w_st_ready;
  assign ld_ready_o = w_ld_ready;
  assign ld_valid_o = r_ld_valid;
  assign ld_data_o  = r_ld_data;
  assign misalign_o = r_misalign;

endmodule
`default_nettype wire
